// File: rtl/slot_switch_conditioner_pkg.sv
// Shared constants and types for the slot-machine reel switch front end.
// Imported by the conditioner top and its per-channel debouncer.
package slot_pkg;

   localparam int SLOT_REELS              = 4;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
   localparam int CLK_HZ                  = 100_000_000;

   // The debouncer state is never stored separately; it is implied by the window count.
   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_SETTLING = 1'b1
   } deb_state_e;

endpackage

// File: rtl/slot_switch_conditioner_channel.sv
// One reel switch: 2-FF synchroniser, stability counter and registered level/edge outputs.
// lock freezes the clean level and clears the window so nothing stale survives unlock.
module switch_debounce_channel
   import slot_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic basys_clk,
   input  logic reset,
   input  logic sw_raw,
   input  logic lock,
   output logic sw_clean,
   output logic sw_rise,
   output logic sw_fall,
   output logic settling
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q;
   logic             s2_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             clean_q, clean_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             settling_q, settling_d;
   deb_state_e       next_state;

   // Any disagreement that does not last the whole window is discarded by zeroing the count.
   always_comb begin
      clean_d    = clean_q;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      count_d    = count_q;
      next_state = ST_STABLE;
      if (lock) begin
         count_d = '0;
      end else if (s2_q == clean_q) begin
         count_d = '0;
      end else if (count_q < CNT_LAST) begin
         count_d    = count_q + CNT_W'(1);
         next_state = ST_SETTLING;
      end else begin
         clean_d = s2_q;
         count_d = '0;
         rise_d  = s2_q;
         fall_d  = ~s2_q;
      end
      settling_d = (next_state == ST_SETTLING);
   end

   always_ff @(posedge basys_clk or posedge reset) begin
      if (reset) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         count_q    <= '0;
         clean_q    <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         settling_q <= 1'b0;
      end else begin
         s1_q       <= sw_raw;
         s2_q       <= s1_q;
         count_q    <= count_d;
         clean_q    <= clean_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         settling_q <= settling_d;
      end
   end

   assign sw_clean = clean_q;
   assign sw_rise  = rise_q;
   assign sw_fall  = fall_q;
   assign settling = settling_q;

endmodule

// File: rtl/slot_switch_conditioner.sv
// Conditions the raw reel slide switches into clean levels and one-cycle edge pulses.
// Each channel is independent; lock (game complete) freezes all of them together.
module slot_switch_conditioner
   import slot_pkg::*;
#(
   parameter int CHANNELS        = SLOT_REELS,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic                basys_clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] sw_raw,
   input  logic                lock,
   output logic [CHANNELS-1:0] sw_clean,
   output logic [CHANNELS-1:0] sw_rise,
   output logic [CHANNELS-1:0] sw_fall,
   output logic [CHANNELS-1:0] settling
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      switch_debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_chan (
         .basys_clk (basys_clk),
         .reset     (reset),
         .sw_raw    (sw_raw[i]),
         .lock      (lock),
         .sw_clean  (sw_clean[i]),
         .sw_rise   (sw_rise[i]),
         .sw_fall   (sw_fall[i]),
         .settling  (settling[i])
      );
   end

endmodule

// File: tb/tb_slot_switch_conditioner.sv
// Directed bench for slot_switch_conditioner with a short debounce window.
// A streak-based model is checked every cycle; literal checks pin the key timings.
module tb_slot_switch_conditioner;

   localparam int CH  = 4;
   localparam int DEB = 4;

   logic          basys_clk = 1'b0;
   logic          reset;
   logic          lock;
   logic [CH-1:0] sw_raw;
   logic [CH-1:0] sw_clean;
   logic [CH-1:0] sw_rise;
   logic [CH-1:0] sw_fall;
   logic [CH-1:0] settling;

   int total = 0;
   int bad   = 0;

   logic [CH-1:0] m_s1, m_s2, m_clean, m_rise, m_fall;
   int            m_run [CH];

   slot_switch_conditioner #(
      .CHANNELS        (CH),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .basys_clk (basys_clk),
      .reset     (reset),
      .sw_raw    (sw_raw),
      .lock      (lock),
      .sw_clean  (sw_clean),
      .sw_rise   (sw_rise),
      .sw_fall   (sw_fall),
      .settling  (settling)
   );

   always #5 basys_clk = ~basys_clk;

   task automatic checkOutput(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [CH-1:0] raw, input logic lk);
      @(negedge basys_clk);
      sw_raw = raw;
      lock   = lk;
   endtask

   task automatic waitEdges(input int n);
      repeat (n) @(posedge basys_clk);
      #1;
   endtask

   // Model: a clean level flips once the synchronised input has disagreed with it for DEB cycles in a row.
   initial begin
      logic [CH-1:0] s2_seen;
      logic [CH-1:0] exp_settling;
      forever begin
         @(posedge basys_clk);
         if (reset) begin
            m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
            for (int i = 0; i < CH; i++) m_run[i] = 0;
         end else begin
            s2_seen = m_s2;
            m_rise  = '0;
            m_fall  = '0;
            for (int i = 0; i < CH; i++) begin
               if (lock || s2_seen[i] == m_clean[i]) begin
                  m_run[i] = 0;
               end else begin
                  m_run[i]++;
                  if (m_run[i] == DEB) begin
                     m_clean[i] = s2_seen[i];
                     m_rise[i]  = s2_seen[i];
                     m_fall[i]  = !s2_seen[i];
                     m_run[i]   = 0;
                  end
               end
            end
            m_s2 = m_s1;
            m_s1 = sw_raw;
         end
         #1;
         for (int i = 0; i < CH; i++) exp_settling[i] = (m_run[i] != 0);
         checkOutput("model_clean", sw_clean, m_clean);
         checkOutput("model_rise", sw_rise, m_rise);
         checkOutput("model_fall", sw_fall, m_fall);
         checkOutput("model_settling", settling, exp_settling);
      end
   end

   initial begin
      reset  = 1'b1;
      lock   = 1'b0;
      sw_raw = 4'hF;
      repeat (2) @(negedge basys_clk);
      #1;
      checkOutput("reset_clean", sw_clean, 4'h0);
      checkOutput("reset_rise", sw_rise, 4'h0);
      checkOutput("reset_fall", sw_fall, 4'h0);
      checkOutput("reset_settling", settling, 4'h0);

      // Reset release with all switches up.
      @(negedge basys_clk);
      reset = 1'b0;
      waitEdges(5);
      checkOutput("release_clean_e4", sw_clean, 4'h0);
      waitEdges(1);
      checkOutput("release_clean_e5", sw_clean, 4'hF);
      checkOutput("release_rise_e5", sw_rise, 4'hF);
      waitEdges(1);
      checkOutput("release_rise_e6", sw_rise, 4'h0);

      // Bounce on channel 0.
      applyStimulus(4'hE, 1'b0);
      waitEdges(10);
      checkOutput("bounce_pre_clean", sw_clean, 4'hE);
      applyStimulus(4'hF, 1'b0);
      applyStimulus(4'hE, 1'b0);
      applyStimulus(4'hF, 1'b0);
      applyStimulus(4'hE, 1'b0);
      applyStimulus(4'hF, 1'b0);
      waitEdges(5);
      checkOutput("bounce_clean_e4", sw_clean, 4'hE);
      checkOutput("bounce_rise_e4", sw_rise, 4'h0);
      waitEdges(1);
      checkOutput("bounce_clean_e5", sw_clean, 4'hF);
      checkOutput("bounce_rise_e5", sw_rise, 4'h1);

      // Three-cycle glitch on channel 2.
      applyStimulus(4'hB, 1'b0);
      waitEdges(10);
      checkOutput("glitch_pre_clean", sw_clean, 4'hB);
      applyStimulus(4'hF, 1'b0);
      waitEdges(3);
      checkOutput("glitch_settling", settling, 4'h4);
      applyStimulus(4'hB, 1'b0);
      waitEdges(10);
      checkOutput("glitch_clean", sw_clean, 4'hB);
      checkOutput("glitch_settled", settling, 4'h0);

      // Simultaneous channel changes.
      applyStimulus(4'h0, 1'b0);
      waitEdges(10);
      checkOutput("simul_pre_clean", sw_clean, 4'h0);
      applyStimulus(4'hA, 1'b0);
      waitEdges(5);
      checkOutput("simul_rise_e4", sw_rise, 4'h0);
      waitEdges(1);
      checkOutput("simul_rise_A", sw_rise, 4'hA);
      checkOutput("simul_fall_A", sw_fall, 4'h0);
      applyStimulus(4'h5, 1'b0);
      waitEdges(6);
      checkOutput("swap_rise", sw_rise, 4'h5);
      checkOutput("swap_fall", sw_fall, 4'hA);
      checkOutput("swap_clean", sw_clean, 4'h5);

      // Lock freezes outputs while switches move.
      applyStimulus(4'hF, 1'b0);
      waitEdges(10);
      checkOutput("lock_pre_clean", sw_clean, 4'hF);
      applyStimulus(4'h0, 1'b1);
      waitEdges(10);
      checkOutput("lock_clean", sw_clean, 4'hF);
      checkOutput("lock_fall", sw_fall, 4'h0);
      checkOutput("lock_settling", settling, 4'h0);
      applyStimulus(4'h0, 1'b0);
      waitEdges(3);
      checkOutput("unlock_fall_e2", sw_fall, 4'h0);
      checkOutput("unlock_settling_e2", settling, 4'hF);
      waitEdges(1);
      checkOutput("unlock_fall_e3", sw_fall, 4'hF);
      checkOutput("unlock_clean_e3", sw_clean, 4'h0);

      // Reset in the middle of a window.
      applyStimulus(4'hF, 1'b0);
      waitEdges(4);
      checkOutput("midrst_settling_pre", settling, 4'hF);
      @(negedge basys_clk);
      reset = 1'b1;
      #1;
      checkOutput("midrst_settling", settling, 4'h0);
      checkOutput("midrst_clean", sw_clean, 4'h0);
      checkOutput("midrst_rise", sw_rise, 4'h0);
      @(negedge basys_clk);
      reset = 1'b0;
      waitEdges(5);
      checkOutput("midrst_clean_e4", sw_clean, 4'h0);
      waitEdges(1);
      checkOutput("midrst_clean_e5", sw_clean, 4'hF);
      checkOutput("midrst_rise_e5", sw_rise, 4'hF);

      waitEdges(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
